// File: rtl/ulpi_rx_bit_parser.sv
`timescale 1ns/1ps
// ULPI receive-side parser: splits RX CMD bytes from packet data and
// serializes buffered data bytes LSB-first into a bit-serial FIFO.
module ulpi_rx_bit_parser #(
    parameter int BUF_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    input  logic [7:0] ulpi_data,
    input  logic       fifo_full,
    output logic       bit_out,
    output logic       bit_valid,
    output logic [7:0] rx_cmd,
    output logic       rx_cmd_strobe,
    output logic       pkt_active,
    output logic       pkt_end,
    output logic       byte_drop
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TURN_IN  = 2'd1,
        RECV     = 2'd2,
        TURN_OUT = 2'd3
    } state_t;

    state_t        state_q;
    logic [7:0]    mem_q [BUF_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [7:0]    sr_q;
    logic [2:0]    idx_q;
    logic          sr_valid_q;
    logic [7:0]    rx_cmd_q;
    logic          strobe_q;
    logic          pkt_end_q;
    logic          drop_q;

    logic push_req;
    logic push_ok;
    logic consume;
    logic last_bit;
    logic pop;

    assign push_req = (state_q == RECV) && ulpi_dir && ulpi_nxt;
    assign push_ok  = push_req && (count_q < CW'(BUF_DEPTH));
    assign consume  = sr_valid_q && !fifo_full;
    assign last_bit = consume && (idx_q == 3'd7);
    // Loading happens into an empty register or on the edge that retires bit 7.
    assign pop      = (count_q != '0) && (!sr_valid_q || last_bit);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= ulpi_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sr_q       <= 8'h00;
            idx_q      <= 3'd0;
            sr_valid_q <= 1'b0;
            rx_cmd_q   <= 8'h00;
            strobe_q   <= 1'b0;
            pkt_end_q  <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            strobe_q  <= 1'b0;
            pkt_end_q <= 1'b0;
            count_q   <= count_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (push_req && !push_ok) begin
                drop_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (ulpi_dir) begin
                        state_q <= TURN_IN;
                        drop_q  <= 1'b0;
                    end
                end
                TURN_IN: begin
                    state_q <= ulpi_dir ? RECV : IDLE;
                end
                RECV: begin
                    if (!ulpi_dir) begin
                        state_q   <= TURN_OUT;
                        pkt_end_q <= 1'b1;
                    end else if (!ulpi_nxt) begin
                        rx_cmd_q <= ulpi_data;
                        strobe_q <= 1'b1;
                    end
                end
                TURN_OUT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            if (pop) begin
                sr_q       <= mem_q[rd_ptr_q];
                rd_ptr_q   <= rd_ptr_q + AW'(1);
                idx_q      <= 3'd0;
                sr_valid_q <= 1'b1;
            end else if (last_bit) begin
                idx_q      <= 3'd0;
                sr_valid_q <= 1'b0;
            end else if (consume) begin
                idx_q <= idx_q + 3'd1;
            end
        end
    end

    assign bit_valid     = consume;
    assign bit_out       = sr_valid_q && sr_q[idx_q];
    assign rx_cmd        = rx_cmd_q;
    assign rx_cmd_strobe = strobe_q;
    assign pkt_active    = (state_q == RECV);
    assign pkt_end       = pkt_end_q;
    assign byte_drop     = drop_q;

endmodule

// File: tb/tb_ulpi_rx_bit_parser.sv
`timescale 1ns/1ps
// Scoreboard bench: stimulus pushes expected bits / RX CMDs into queues,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_ulpi_rx_bit_parser;

    logic       clk = 1'b0;
    logic       rst;
    logic       ulpi_dir;
    logic       ulpi_nxt;
    logic [7:0] ulpi_data;
    logic       fifo_full;
    logic       bit_out;
    logic       bit_valid;
    logic [7:0] rx_cmd;
    logic       rx_cmd_strobe;
    logic       pkt_active;
    logic       pkt_end;
    logic       byte_drop;

    int errors = 0;
    int checks = 0;
    int bits_seen = 0;
    int pkt_end_cnt = 0;
    int strobe_cnt = 0;
    logic exp_bits [$];
    logic [7:0] exp_cmds [$];

    ulpi_rx_bit_parser #(.BUF_DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .ulpi_dir(ulpi_dir),
        .ulpi_nxt(ulpi_nxt),
        .ulpi_data(ulpi_data),
        .fifo_full(fifo_full),
        .bit_out(bit_out),
        .bit_valid(bit_valid),
        .rx_cmd(rx_cmd),
        .rx_cmd_strobe(rx_cmd_strobe),
        .pkt_active(pkt_active),
        .pkt_end(pkt_end),
        .byte_drop(byte_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented bit and RX CMD must match the next expected one.
    always @(negedge clk) begin
        if (bit_valid) begin
            bits_seen++;
            checks++;
            if (exp_bits.size() == 0) begin
                errors++;
                $display("FAIL bit_unexpected: got bit %0b with nothing expected",
                         bit_out);
            end else begin
                logic e;
                e = exp_bits.pop_front();
                if (bit_out !== e) begin
                    errors++;
                    $display("FAIL bit_out: got %0b expected %0b", bit_out, e);
                end
            end
        end
        if (rx_cmd_strobe) begin
            strobe_cnt++;
            checks++;
            if (exp_cmds.size() == 0) begin
                errors++;
                $display("FAIL cmd_unexpected: got rx_cmd %0h", rx_cmd);
            end else begin
                logic [7:0] c;
                c = exp_cmds.pop_front();
                if (rx_cmd !== c) begin
                    errors++;
                    $display("FAIL rx_cmd: got %0h expected %0h", rx_cmd, c);
                end
            end
        end
        if (pkt_end) pkt_end_cnt++;
    end

    task automatic cycle(input logic d, input logic n, input logic [7:0] v);
        ulpi_dir  = d;
        ulpi_nxt  = n;
        ulpi_data = v;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_byte(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) exp_bits.push_back(b[i]);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_bits.size() != 0 && n < 200) begin
            cycle(1'b0, 1'b0, 8'h00);
            n++;
        end
        repeat (4) cycle(1'b0, 1'b0, 8'h00);
        chk(name, exp_bits.size(), 0);
    endtask

    task automatic wait_bits(input string name, input int target);
        int n;
        n = 0;
        while (bits_seen < target && n < 100) begin
            cycle(1'b0, 1'b0, 8'h00);
            n++;
        end
        chk(name, (bits_seen >= target) ? 1 : 0, 1);
    endtask

    task automatic enter_recv();
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        ulpi_dir = 1'b0;
        ulpi_nxt = 1'b0;
        ulpi_data = 8'h00;
        fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_outputs", {bit_out, bit_valid, rx_cmd, rx_cmd_strobe,
                              pkt_active, pkt_end, byte_drop}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: single dir cycle lands in TURN_IN, byte ignored
        cycle(1'b1, 1'b1, 8'hA5);
        cycle(1'b0, 1'b0, 8'h00);
        repeat (12) cycle(1'b0, 1'b0, 8'h00);
        chk("t1_no_bits", bits_seen, 0);
        chk("t1_no_pkt_end", pkt_end_cnt, 0);
        chk("t1_idle", pkt_active, 0);

        // 2: one data byte, then packet end
        enter_recv();
        chk("t2_active", pkt_active, 1);
        exp_byte(8'hA5, 8);
        cycle(1'b1, 1'b1, 8'hA5);
        cycle(1'b0, 1'b0, 8'h00);
        drain("t2_drain");
        chk("t2_bits", bits_seen, 8);
        chk("t2_pkt_end", pkt_end_cnt, 1);
        chk("t2_inactive", pkt_active, 0);

        // 3: RX CMD
        enter_recv();
        exp_cmds.push_back(8'h4E);
        cycle(1'b1, 1'b0, 8'h4E);
        cycle(1'b0, 1'b0, 8'h00);
        repeat (12) cycle(1'b0, 1'b0, 8'h00);
        chk("t3_strobes", strobe_cnt, 1);
        chk("t3_cmd_pending", exp_cmds.size(), 0);
        chk("t3_rx_cmd_held", rx_cmd, 8'h4E);
        chk("t3_no_bits", bits_seen, 8);

        // 4: overflow, sixth byte dropped
        enter_recv();
        chk("t4_drop_clear", byte_drop, 0);
        for (int b = 1; b <= 5; b++) exp_byte(8'(b), 8);
        for (int b = 1; b <= 6; b++) cycle(1'b1, 1'b1, 8'(b));
        cycle(1'b0, 1'b0, 8'h00);
        chk("t4_drop_set", byte_drop, 1);
        drain("t4_drain");
        chk("t4_bits", bits_seen, 48);
        chk("t4_drop_sticky", byte_drop, 1);
        cycle(1'b1, 1'b0, 8'h00);
        chk("t4_drop_cleared", byte_drop, 0);
        cycle(1'b0, 1'b0, 8'h00);
        repeat (2) cycle(1'b0, 1'b0, 8'h00);

        // 5: stall after bit 2
        base = bits_seen;
        enter_recv();
        exp_byte(8'hFF, 8);
        cycle(1'b1, 1'b1, 8'hFF);
        cycle(1'b0, 1'b0, 8'h00);
        wait_bits("t5_reach_bit2", base + 3);
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_stalled", bit_valid, 0);
            @(posedge clk);
            #1;
        end
        fifo_full = 1'b0;
        drain("t5_drain");
        chk("t5_total_bits", bits_seen - base, 8);

        // 6: reset during bit 4 of C3 with two bytes buffered
        base = bits_seen;
        enter_recv();
        exp_byte(8'hC3, 5);
        cycle(1'b1, 1'b1, 8'hC3);
        cycle(1'b1, 1'b1, 8'h11);
        cycle(1'b1, 1'b1, 8'h22);
        cycle(1'b0, 1'b0, 8'h00);
        wait_bits("t6_reach_bit3", base + 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_reset_outputs", {bit_out, bit_valid, rx_cmd, rx_cmd_strobe,
                                 pkt_active, pkt_end, byte_drop}, 0);
        @(posedge clk);
        #1;
        repeat (30) cycle(1'b0, 1'b0, 8'h00);
        chk("t6_bits", bits_seen - base, 5);
        chk("t6_pending", exp_bits.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ulpi_rx_bit_parser.md
Name: ulpi_rx_bit_parser

Overview:
- Upstream stage of the bit-serial FIFO stack in the USB3300 receive path.
- Watches the ULPI receive side (dir/nxt/data) and separates RX CMD bytes from packet data bytes.
- Buffers data bytes and serializes them LSB-first, one bit per clock, into the FIFO's data_in/in_ctrl pair.
- Reports packet framing and byte drops to the controller.

Parameters:
- BUF_DEPTH, 4: data-byte buffer depth in bytes. Power of two, ≥2.

Ports:
- clk  in  1  system clock (60 MHz ULPI clock domain).
- rst  in  1  reset. Synchronous, active-high.
- ulpi_dir  in  1  PHY bus direction; 1 = PHY drives data.
- ulpi_nxt  in  1  PHY next strobe.
- ulpi_data  in  8  ULPI data bus.
- fifo_full  in  1  downstream FIFO cannot accept a bit; stalls the serializer.
- bit_out  out  1  serial data to the FIFO's data_in.
- bit_valid  out  1  drives the FIFO's in_ctrl; bit_out is valid this cycle.
- rx_cmd  out  8  last RX CMD byte received.
- rx_cmd_strobe  out  1  one-cycle pulse when rx_cmd updates.
- pkt_active  out  1  high while state = RECV.
- pkt_end  out  1  one-cycle pulse when dir falls in RECV.
- byte_drop  out  1  sticky; set when a data byte is lost because the buffer is full.

Behaviour:
- Reset:
  - All outputs 0; rx_cmd = 8'h00.
  - State IDLE; buffer count 0; shift register empty.
  - Reset asserted mid-packet discards all buffered and partially shifted bits.
- Bus FSM (sampled on the rising clk edge):
  - IDLE: dir=1 -> TURN_IN. ulpi_data is ignored.
  - TURN_IN (turnaround cycle, data ignored): dir=1 -> RECV; dir=0 -> IDLE. Entering TURN_IN clears byte_drop.
  - RECV:
    - dir=1, nxt=1: data byte pushed to the buffer.
    - dir=1, nxt=0: rx_cmd <= ulpi_data; rx_cmd_strobe pulses the next cycle.
    - dir=0: -> TURN_OUT, and pkt_end pulses for one cycle.
  - TURN_OUT: unconditionally -> IDLE.
- Byte buffer:
  - Circular FIFO of BUF_DEPTH bytes. Pointers wrap modulo BUF_DEPTH; count width is clog2(BUF_DEPTH)+1.
  - A push is accepted only if count < BUF_DEPTH at the start of the cycle. A pop in the same cycle does not free a slot for that push.
  - A push that is rejected discards the byte and sets byte_drop.
  - Simultaneous accepted push and pop: count unchanged, both pointers advance.
- Serializer:
  - Holds an 8-bit shift register and a 3-bit bit index.
  - When the shift register is empty and the buffer is non-empty, it pops one byte into the register at the clock edge.
  - After loading, it presents bit[0] on bit_out with bit_valid=1, then bits 1..7 on consecutive non-stalled cycles.
  - bit_valid = register non-empty AND fifo_full=0. When fifo_full=1, bit_valid=0 and bit_out and the index hold.
  - On the edge that consumes bit 7, the next byte loads if one is available. This gives back-to-back bytes with no gap.
- Latency and throughput:
  - Byte pushed at edge E with buffer and serializer idle: load at E+1, bit0 valid in the cycle after E+1, bit7 valid after E+8.
  - Sustained throughput is 1 byte per 8 cycles. ULPI bursts faster than that are absorbed by BUF_DEPTH; any excess sets byte_drop.
- End of packet:
  - The serializer keeps draining after dir falls.
  - pkt_end does not wait for the drain.
- RX CMD handling: RX CMD bytes never enter the buffer or the bit stream.

Test Plan:
1. Reset, then dir=1 for 1 cycle with nxt=1, data=8'hA5 -> TURN_IN ignores the byte; no bit_valid; returns to IDLE.
2. dir rises; next cycle nxt=1, data=8'hA5 for 1 cycle; then dir=0 -> bit_out sequence 1,0,1,0,0,1,0,1 on 8 consecutive bit_valid cycles; pkt_end pulses once; pkt_active low after.
3. In RECV, nxt=0 with data=8'h4E -> rx_cmd=8'h4E, one-cycle rx_cmd_strobe, no bit_valid.
4. BUF_DEPTH=4, six back-to-back data bytes 8'h01..8'h06 -> first 5 bytes serialized in order (one held in the shift register, four buffered); 8'h06 dropped; byte_drop=1 until the next dir rise.
5. Byte 8'hFF mid-shift with fifo_full=1 for 3 cycles after bit 2 -> bit_valid low for 3 cycles, then bits 3..7 resume; exactly 8 valid bits total.
6. rst asserted during bit 4 of 8'hC3 with 2 bytes buffered -> next cycle all outputs 0, no further bit_valid, byte_drop=0.
